// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - uart_state_t / IDLE, START, DATA, STOP: frame FSM state encoding
//   - uart_cycle(): clocks per bit from clock frequency and baud rate
//   - uart_cnt_w(): width of a counter that must hold 0 .. cycle-1
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t IDLE  = 2'd0;
  localparam uart_state_t START = 2'd1;
  localparam uart_state_t DATA  = 2'd2;
  localparam uart_state_t STOP  = 2'd3;

  function automatic int unsigned uart_cycle(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Never narrower than one bit so degenerate rates still elaborate.
  function automatic int unsigned uart_cnt_w(input int unsigned cycle);
    return (cycle < 2) ? 1 : $clog2(cycle);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2: two-flop synchroniser for an asynchronous single-bit input.
//   clk      in  system clock
//   rst      in  asynchronous, active-high reset
//   i_async  in  asynchronous input
//   o_sync   out synchronised copy of i_async (2 clocks latency)
// RST_VAL sets the value both flops take in reset (line-idle level).
// ---------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx: 8N1 UART receiver with valid/ready output handshake.
//   clk            in  system clock, rising edge
//   rst            in  asynchronous, active-high reset
//   rx             in  serial line (asynchronous, idle high)
//   rx_data        out received byte, stable while rx_data_valid
//   rx_data_valid  out byte available, held until accepted
//   rx_data_ready  in  consumer accepts byte when high with rx_data_valid
//   rx_frame_err   out 1-cycle pulse: stop bit low, byte discarded
//   rx_overrun     out 1-cycle pulse: unaccepted byte overwritten
//   rx_busy        out FSM not in IDLE
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int unsigned CYCLE = uart_cycle(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF  = CYCLE / 2;
  localparam int unsigned CNT_W = uart_cnt_w(CYCLE);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  logic              w_rx_s;
  logic              w_xfer;
  uart_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_rx_prev;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_overrun;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  assign w_xfer = r_valid & rx_data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_prev   <= 1'b1;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_prev   <= w_rx_s;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // A byte completing below overrides this clear, so a transfer and a
      // completion in the same cycle leave the new byte valid.
      if (w_xfer) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (r_rx_prev && !w_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end

        START: begin
          if (r_cnt == CNT_MID) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Counting a full bit from mid-start lands every sample mid-bit.
        DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (w_rx_s) begin
              r_data    <= r_shift;
              r_valid   <= 1'b1;
              r_overrun <= r_valid & ~rx_data_ready;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign rx_data       = r_data;
  assign rx_data_valid = r_valid;
  assign rx_frame_err  = r_frame_err;
  assign rx_overrun    = r_overrun;
  assign rx_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx: self-checking bench for uart_rx at CLK_FREQ=160, BAUD_RATE=10
// (16 clocks per bit). A serial driver produces frames; a monitor records
// accepted bytes and pulse counts; expectations come from a byte-queue model.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int unsigned PER = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned valid_cycles = 0;
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;
  logic        mon_prev_valid = 1'b0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.CLK_FREQ(160), .BAUD_RATE(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observation only: bytes accepted by the consumer and pulse counts.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_data_valid) valid_cycles++;
      if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data);
      if (rx_frame_err) fe_cnt++;
      if (rx_overrun) ov_cnt++;
      if (rx_data_valid && !mon_prev_valid) rise_cyc = cyc;
    end
    mon_prev_valid = rx_data_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare accepted bytes against the model queue, then start afresh.
  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_byte"}, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD_BEEF,
          {24'h0, exp_q[i]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_bit(input logic v, input int unsigned per);
    rx = v;
    repeat (per) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [7:0] b, input int unsigned per);
    start_cyc = cyc;
    drive_bit(1'b0, per);
    for (int unsigned i = 0; i < 8; i++) drive_bit(b[i], per);
  endtask

  task automatic send_frame(input logic [7:0] b, input int unsigned per, input logic stop);
    send_head(b, per);
    drive_bit(stop, per);
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned vc0;
    int unsigned fe0;
    int unsigned ov0;
    int unsigned lat;
    logic [7:0]  b;
    logic [7:0]  dir_bytes[5];

    rst = 1'b1;
    rx = 1'b1;
    rx_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_data_valid, 1'b0);
    chk("rst_ferr", rx_frame_err, 1'b0);
    chk("rst_ovr", rx_overrun, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    rst = 1'b0;
    idle(5);

    // Directed bytes back-to-back, ready tied high.
    dir_bytes = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80};
    vc0 = valid_cycles;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) begin
      send_frame(dir_bytes[i], PER, 1'b1);
      exp_q.push_back(dir_bytes[i]);
      if (i == 0) begin
        lat = rise_cyc - start_cyc;
        chk("latency", (lat >= 9 * PER + PER / 2 + 3) && (lat <= 9 * PER + PER / 2 + 5), 1'b1);
      end
    end
    idle(10);
    check_stream("b2b");
    chk("b2b_valid_cycles", valid_cycles - vc0, 5);
    chk("b2b_ferr", fe_cnt - fe0, 0);
    chk("b2b_ovr", ov_cnt - ov0, 0);

    // Start-bit glitch.
    vc0 = valid_cycles;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("glitch_busy_hi", rx_busy, 1'b1);
    idle(12);
    chk("glitch_busy_lo", rx_busy, 1'b0);
    chk("glitch_valid", valid_cycles - vc0, 0);
    chk("glitch_ferr", fe_cnt - fe0, 0);

    // Framing error, then break, then clean byte.
    vc0 = valid_cycles;
    fe0 = fe_cnt;
    send_frame(8'h3C, PER, 1'b0);
    drive_bit(1'b0, 40);
    chk("ferr_pulse", fe_cnt - fe0, 1);
    chk("ferr_valid", valid_cycles - vc0, 0);
    chk("ferr_busy_break", rx_busy, 1'b0);
    idle(20);
    send_frame(8'h55, PER, 1'b1);
    exp_q.push_back(8'h55);
    idle(10);
    check_stream("after_break");
    chk("after_break_ferr", fe_cnt - fe0, 1);

    // Overrun, handshake release, completion coinciding with transfer.
    ov0 = ov_cnt;
    rx_data_ready = 1'b0;
    send_frame(8'h11, PER, 1'b1);
    send_frame(8'h22, PER, 1'b1);
    idle(10);
    chk("ovr_data", rx_data, 8'h22);
    chk("ovr_valid", rx_data_valid, 1'b1);
    chk("ovr_pulse", ov_cnt - ov0, 1);
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_valid_clear", rx_data_valid, 1'b0);
    rx_data_ready = 1'b0;
    exp_q.push_back(8'h22);
    send_frame(8'h66, PER, 1'b1);
    exp_q.push_back(8'h66);
    send_head(8'h33, PER);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("same_cycle_valid", rx_data_valid, 1'b1);
    chk("same_cycle_data", rx_data, 8'h33);
    chk("same_cycle_ovr", ov_cnt - ov0, 1);
    exp_q.push_back(8'h33);
    idle(10);
    check_stream("handshake");

    // Random bytes at nominal rate with random idle gaps.
    vc0 = valid_cycles;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send_frame(b, PER, 1'b1);
      exp_q.push_back(b);
      idle($urandom_range(0, 5));
    end
    idle(10);
    check_stream("random");
    chk("random_valid_cycles", valid_cycles - vc0, 8);

    // Transmitter bit period off by one clock either way.
    send_frame(8'hC3, PER - 1, 1'b1);
    exp_q.push_back(8'hC3);
    idle(20);
    send_frame(8'hC3, PER + 1, 1'b1);
    exp_q.push_back(8'hC3);
    idle(20);
    check_stream("baud_tol");

    // Reset during DATA bit 4 with a byte pending.
    fe0 = fe_cnt;
    rx_data_ready = 1'b0;
    send_frame(8'h5A, PER, 1'b1);
    drive_bit(1'b0, PER);
    b = 8'h7E;
    for (int unsigned i = 0; i < 4; i++) drive_bit(b[i], PER);
    drive_bit(b[4], PER / 2);
    chk("pre_rst_busy", rx_busy, 1'b1);
    chk("pre_rst_valid", rx_data_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_valid", rx_data_valid, 1'b0);
    chk("mid_rst_busy", rx_busy, 1'b0);
    chk("mid_rst_ferr", rx_frame_err, 1'b0);
    chk("mid_rst_ovr", rx_overrun, 1'b0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    rx_data_ready = 1'b1;
    send_frame(8'h7E, PER, 1'b1);
    exp_q.push_back(8'h7E);
    idle(10);
    check_stream("post_rst");
    chk("post_rst_ferr", fe_cnt - fe0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
